iram_arbiter: RTL and testbench

//  Two-master arbiter and sequencer in front of the single-port iram slave (HWRITE/HADDR/HWDATA/HRDATA).

---
 rtl/iram_arb_pkg.sv | 35 +++
 rtl/iram_arb_prio.sv | 55 +++++
 rtl/iram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_iram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iram_arb_pkg.sv
// iram_arb_pkg
//   Shared types and helpers for the iram two-master arbiter.
//   - state_t : sequencer states (IDLE -> ACCESS -> RESP)
//   - owner_t : which master owns the in-flight access
//   - addr_legal() : window + alignment check for a request address
package iram_arb_pkg;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // The last 8-byte word of the window is deliberately excluded: the upper
  // bound is start + size - 8, compared as a strict less-than at full width.
  function automatic logic addr_legal(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] start,
    input logic [ADDR_W-1:0] size
  );
    logic [ADDR_W-1:0] limit;
    limit = start + size - ADDR_W'(8);
    return (addr >= start) && (addr < limit) && (addr[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/iram_arb_prio.sv
// iram_arb_prio
//   Winner selection between fetch and load/store, plus the fetch starvation
//   counter. Load/store normally wins; once fetch has lost STARVE_MAX
//   arbitration cycles in a row it wins the next one.
// Ports
//   clk, rst  : clock, async active-high reset
//   if_req    : fetch request
//   ls_req    : load/store request
//   arb_en    : this cycle is an arbitration cycle
//   grant_if  : fetch wins (combinational)
//   grant_ls  : load/store wins (combinational)
module iram_arb_prio
  import iram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ls_req,
  input  logic arb_en,
  output logic grant_if,
  output logic grant_ls
);

  logic [STARVE_W-1:0] starve_cnt;
  logic                if_boost;

  assign if_boost = (starve_cnt == STARVE_W'(STARVE_MAX));

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (arb_en) begin
      if (ls_req && !(if_req && if_boost)) begin
        grant_ls = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // In the increment branch grant_if is known low, so arb_en && if_req
  // means fetch asked and lost this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (arb_en && if_req && (starve_cnt != '1)) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/iram_arbiter.sv
// iram_arbiter
//   Shares the single-port iram between the instruction-fetch port
//   (read-only) and the load/store port (read/write). Every access takes
//   three cycles: accept (gnt), bus (HADDR/HWRITE driven), response (rvalid).
//   Arbitration runs in IDLE and RESP, giving one access per two cycles.
//   When no legal access is on the bus, HWRITE is low and HADDR is parked.
// Ports
//   clk, rst                      : clock, async active-high reset
//   if_req/if_addr                : fetch request
//   if_gnt/if_rvalid/if_rdata/if_err : fetch accept and response
//   ls_req/ls_write/ls_addr/ls_wdata : load/store request
//   ls_gnt/ls_rvalid/ls_rdata/ls_err : load/store accept and response
//   HWRITE/HADDR/HWDATA/HRDATA    : iram slave interface
//
// state  | meaning
// IDLE   | no access in flight; arbitrate
// ACCESS | latched request on the bus (or parked if illegal)
// RESP   | owner's rvalid pulse; arbitrate the next request
module iram_arbiter
  import iram_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RAM_START  = 64'h1000,
  parameter int unsigned       RAM_SIZE   = 256,
  parameter int unsigned       STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] PARK_ADDR  = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              HWRITE,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA
);

  state_t              state, state_nxt;
  owner_t              owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q;
  logic                legal_q;

  logic                arb_en;
  logic                grant_if, grant_ls, grant_any;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_write;
  logic                req_legal;
  logic [DATA_W-1:0]   access_rdata;

  // Gating with rst keeps gnt low while reset is held, even though the
  // state register already reads IDLE.
  assign arb_en = ((state == IDLE) || (state == RESP)) && !rst;

  iram_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .ls_req   (ls_req),
    .arb_en   (arb_en),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  assign if_gnt    = grant_if;
  assign ls_gnt    = grant_ls;
  assign grant_any = grant_if | grant_ls;

  assign req_addr  = grant_ls ? ls_addr : if_addr;
  assign req_write = grant_ls & ls_write;
  assign req_wdata = grant_ls ? ls_wdata : '0;
  assign req_legal = addr_legal(req_addr, RAM_START, ADDR_W'(RAM_SIZE));

  // Stores and illegal accesses return zero data.
  assign access_rdata = (legal_q && !write_q) ? HRDATA : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    HADDR     = PARK_ADDR;
    HWRITE    = 1'b0;
    HWDATA    = '0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = grant_any ? ACCESS : IDLE;
      end
      ACCESS: begin
        state_nxt = RESP;
        if (legal_q) begin
          HADDR  = addr_q;
          HWRITE = write_q;
          HWDATA = wdata_q;
        end
      end
      RESP: begin
        state_nxt = grant_any ? ACCESS : IDLE;
        if_rvalid = (owner_q == OWN_IF);
        ls_rvalid = (owner_q == OWN_LS);
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      legal_q <= 1'b0;
    end else if (grant_any) begin
      owner_q <= grant_ls ? OWN_LS : OWN_IF;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      write_q <= req_write;
      legal_q <= req_legal;
    end
  end

  // Only the owner's response registers move; the other port keeps its
  // last rdata/err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata <= '0;
      if_err   <= 1'b0;
      ls_rdata <= '0;
      ls_err   <= 1'b0;
    end else if (state == ACCESS) begin
      if (owner_q == OWN_IF) begin
        if_rdata <= access_rdata;
        if_err   <= !legal_q;
      end else begin
        ls_rdata <= access_rdata;
        ls_err   <= !legal_q;
      end
    end
  end

endmodule

// File: tb/tb_iram_arbiter.sv
module tb_iram_arbiter;

  localparam int          STARVE_MAX = 4;
  localparam logic [63:0] PARK       = 64'h0;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req, ls_write, ls_gnt, ls_rvalid, ls_err;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic        HWRITE;
  logic [63:0] HADDR, HWDATA, HRDATA;

  int n_tests = 0;
  int n_fail  = 0;
  int hw_cnt  = 0;

  iram_arbiter #(
    .RAM_START  (64'h1000),
    .RAM_SIZE   (256),
    .STARVE_MAX (STARVE_MAX),
    .PARK_ADDR  (PARK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .ls_req    (ls_req),
    .ls_write  (ls_write),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_err    (ls_err),
    .HWRITE    (HWRITE),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // iram slave: 256 bytes at 0x1000, combinational read, write on clock edge.
  logic [63:0] ram    [0:31];
  logic [63:0] shadow [0:31];

  always_comb begin
    HRDATA = '0;
    if (HADDR >= 64'h1000 && HADDR < 64'h1100) HRDATA = ram[HADDR[7:3]];
  end

  always @(posedge clk) begin
    if (HWRITE && HADDR >= 64'h1000 && HADDR < 64'h1100) ram[HADDR[7:3]] = HWDATA;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [63:0] a);
    logic [63:0] x;
    x = a;
    return (x >= 64'h1000) && (x <= 64'h10F0) && (x % 8 == 0);
  endfunction

  // Transaction-level model: an access granted in cycle N occupies the bus in
  // N+1 and responds in N+2; no grant is possible while a bus cycle is running.
  typedef struct packed {
    logic        v;
    logic        own_ls;
    logic [63:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic        ok;
    logic [63:0] rdata;
  } stage_t;

  stage_t acc, rsp;
  int     lost;

  always @(negedge clk) begin
    logic e_if, e_ls;
    if (rst) begin
      acc  = '0;
      rsp  = '0;
      lost = 0;
    end else begin
      if (HWRITE) hw_cnt++;
      e_if = 1'b0;
      e_ls = 1'b0;
      if (!acc.v) begin
        if (if_req && ls_req) begin
          if (lost >= STARVE_MAX) e_if = 1'b1;
          else e_ls = 1'b1;
        end else if (if_req) e_if = 1'b1;
        else if (ls_req) e_ls = 1'b1;
      end
      check("if_gnt", 64'(if_gnt), 64'(e_if));
      check("ls_gnt", 64'(ls_gnt), 64'(e_ls));

      if (acc.v && acc.ok) begin
        check("HADDR", HADDR, acc.addr);
        check("HWRITE", 64'(HWRITE), 64'(acc.wr));
        if (acc.wr) check("HWDATA", HWDATA, acc.wdata);
      end else begin
        check("HADDR_park", HADDR, PARK);
        check("HWRITE_idle", 64'(HWRITE), 64'd0);
      end

      check("if_rvalid", 64'(if_rvalid), 64'(rsp.v && !rsp.own_ls));
      check("ls_rvalid", 64'(ls_rvalid), 64'(rsp.v && rsp.own_ls));
      if (rsp.v && rsp.own_ls) begin
        check("ls_rdata", ls_rdata, rsp.rdata);
        check("ls_err", 64'(ls_err), 64'(!rsp.ok));
      end
      if (rsp.v && !rsp.own_ls) begin
        check("if_rdata", if_rdata, rsp.rdata);
        check("if_err", 64'(if_err), 64'(!rsp.ok));
      end

      rsp = acc;
      if (acc.v) begin
        rsp.rdata = (acc.ok && !acc.wr) ? shadow[(acc.addr - 64'h1000) / 8] : 64'd0;
        if (acc.ok && acc.wr) shadow[(acc.addr - 64'h1000) / 8] = acc.wdata;
      end
      acc = '0;
      if (e_if || e_ls) begin
        acc.v      = 1'b1;
        acc.own_ls = e_ls;
        acc.addr   = e_ls ? ls_addr : if_addr;
        acc.wr     = e_ls && ls_write;
        acc.wdata  = ls_wdata;
        acc.ok     = legal(acc.addr);
        if (e_if) lost = 0;
        else if (if_req) lost++;
      end
    end
  end

  task automatic xfer(input logic use_ls, input logic wr, input logic [63:0] a,
                      input logic [63:0] d, output logic [63:0] rd, output logic er);
    int  n;
    logic g;
    if (use_ls) begin
      ls_req = 1'b1; ls_write = wr; ls_addr = a; ls_wdata = d;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = use_ls ? ls_gnt : if_gnt;
    end while (!g && n < 20);
    check("gnt_seen", 64'(g), 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0; ls_write = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(use_ls ? ls_rvalid : if_rvalid) && n < 10);
    check("rvalid_latency", 64'(n), 64'd2);
    rd = use_ls ? ls_rdata : if_rdata;
    er = use_ls ? ls_err : if_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [5:0]  seq;
    int          ngr, quiet, rv;
    logic [63:0] if_list [0:2];

    for (int i = 0; i < 32; i++) begin
      ram[i]    = 64'hA5A5_0000_0000_0000 | 64'(i);
      shadow[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    end
    rst = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_write = 0; ls_addr = 0; ls_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_HADDR", HADDR, 64'h0);
    check("rst_HWRITE", 64'(HWRITE), 64'd0);
    check("rst_HWDATA", HWDATA, 64'd0);
    check("rst_ls_rdata", ls_rdata, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: store then load
    hw_cnt = 0;
    xfer(1'b1, 1'b1, 64'h1000, 64'h1122334455667788, rd, er);
    check("t1_store_rdata", rd, 64'd0);
    check("t1_hwrite_cycles", 64'(hw_cnt), 64'd1);
    xfer(1'b1, 1'b0, 64'h1000, 64'd0, rd, er);
    check("t1_load_data", rd, 64'h1122334455667788);
    check("t1_load_err", 64'(er), 64'd0);

    // 2: contention, ls wins four times then fetch
    if_addr = 64'h1008; ls_addr = 64'h1008; ls_write = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    seq = '0; ngr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) begin
        seq = {seq[4:0], if_gnt};
        ngr++;
      end
      @(posedge clk); #1;
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("t2_grant_count", 64'(ngr), 64'd6);
    check("t2_grant_order", 64'(seq), 64'(6'b000010));
    repeat (3) @(posedge clk);
    #1;

    // 3: illegal fetches
    if_list[0] = 64'h0FF8; if_list[1] = 64'h10F8; if_list[2] = 64'h1004;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 1'b0, if_list[i], 64'd0, rd, er);
      check("t3_if_err", 64'(er), 64'd1);
      check("t3_if_rdata", rd, 64'd0);
    end

    // 4: window top
    xfer(1'b1, 1'b1, 64'h10F0, 64'hCAFE_F00D_1234_5678, rd, er);
    check("t4_store_err", 64'(er), 64'd0);
    xfer(1'b1, 1'b0, 64'h10F0, 64'd0, rd, er);
    check("t4_readback", rd, 64'hCAFE_F00D_1234_5678);
    xfer(1'b1, 1'b1, 64'h10F8, 64'hDEAD_BEEF_DEAD_BEEF, rd, er);
    check("t4_oob_err", 64'(er), 64'd1);
    check("t4_oob_mem", ram[31], 64'hA5A5_0000_0000_001F);

    // 5: reset during ACCESS of a load
    ls_req = 1'b1; ls_write = 1'b0; ls_addr = 64'h1010;
    @(negedge clk);
    check("t5_gnt", 64'(ls_gnt), 64'd1);
    @(posedge clk); #1;
    ls_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_HADDR", HADDR, 64'h0);
    check("t5_HWRITE", 64'(HWRITE), 64'd0);
    check("t5_ls_rvalid", 64'(ls_rvalid), 64'd0);
    check("t5_ls_rdata", ls_rdata, 64'd0);
    check("t5_ls_err", 64'(ls_err), 64'd0);
    check("t5_if_err", 64'(if_err), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rv = 0;
    repeat (4) begin
      @(negedge clk);
      if (ls_rvalid || if_rvalid) rv++;
    end
    check("t5_no_rvalid", 64'(rv), 64'd0);
    @(posedge clk); #1;
    xfer(1'b1, 1'b0, 64'h1000, 64'd0, rd, er);
    check("t5_after_rst_load", rd, 64'h1122334455667788);

    // 6: idle bus
    quiet = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_gnt || ls_gnt || if_rvalid || ls_rvalid || HWRITE || HADDR != PARK) quiet++;
    end
    check("t6_idle_quiet", 64'(quiet), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
